// File: rtl/lsu_ctrl.sv
// Load/store controller: one request per handshake, SRAM byte-mask access,
// extended load data through a registered response, saturating access counters.
module lsu_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic             resp_fault,
   output logic [3:0]       sram_w_en,
   output logic [15:0]      sram_address,
   output logic [31:0]      sram_write_data,
   input  logic [31:0]      sram_read_data,
   output logic [CNT_W-1:0] cnt_loads,
   output logic [CNT_W-1:0] cnt_stores,
   output logic [CNT_W-1:0] cnt_faults
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;
   logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
   logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
   logic [CNT_W-1:0]  ft_cnt_q, ft_cnt_d;

   logic [3:0]        mask;
   logic [1:0]        size_m1;
   logic              f3_ok;
   logic [16:0]       end_addr;
   logic              acc_fault;
   logic [31:0]       load_ext;

   // Access decode on the latched request; only meaningful in ACCESS.
   always_comb begin
      mask    = 4'b1111;
      size_m1 = 2'd3;
      case (f3_q[1:0])
         2'b00:   begin mask = 4'b0001; size_m1 = 2'd0; end
         2'b01:   begin mask = 4'b0011; size_m1 = 2'd1; end
         default: begin mask = 4'b1111; size_m1 = 2'd3; end
      endcase
      if (we_q) f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
      else      f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                        (f3_q == 3'b100) || (f3_q == 3'b101);
      end_addr  = {1'b0, addr_q[15:0]} + 17'(size_m1);
      acc_fault = (addr_q[31:16] != 16'd0) || !f3_ok || end_addr[16];
      case (f3_q)
         3'b000:  load_ext = {{24{sram_read_data[7]}}, sram_read_data[7:0]};
         3'b001:  load_ext = {{16{sram_read_data[15]}}, sram_read_data[15:0]};
         3'b100:  load_ext = {24'd0, sram_read_data[7:0]};
         3'b101:  load_ext = {16'd0, sram_read_data[15:0]};
         default: load_ext = sram_read_data;
      endcase
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      ld_cnt_d = ld_cnt_q;
      st_cnt_d = st_cnt_q;
      ft_cnt_d = ft_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = RESP;
            fault_d = acc_fault;
            rdata_d = (acc_fault || we_q) ? 32'd0 : load_ext;
            if (acc_fault) begin
               if (ft_cnt_q != '1) ft_cnt_d = ft_cnt_q + CNT_W'(1);
            end else if (we_q) begin
               if (st_cnt_q != '1) st_cnt_d = st_cnt_q + CNT_W'(1);
            end else begin
               if (ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         f3_q     <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
         ld_cnt_q <= '0;
         st_cnt_q <= '0;
         ft_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         f3_q     <= f3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         ld_cnt_q <= ld_cnt_d;
         st_cnt_q <= st_cnt_d;
         ft_cnt_q <= ft_cnt_d;
      end
   end

   // Outputs decode the state flop so reset clears the write mask immediately.
   assign req_ready       = (state_q == IDLE) && !rst;
   assign resp_valid      = (state_q == RESP);
   assign resp_rdata      = rdata_q;
   assign resp_fault      = fault_q;
   assign sram_w_en       = ((state_q == ACCESS) && we_q && !acc_fault) ? mask : 4'b0000;
   assign sram_address    = addr_q[15:0];
   assign sram_write_data = wdata_q;
   assign cnt_loads       = ld_cnt_q;
   assign cnt_stores      = st_cnt_q;
   assign cnt_faults      = ft_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: request driver with a byte-array reference
// model, decoupled monitor for responses, SRAM writes and counters.
module tb_lsu_ctrl;
   localparam int unsigned CNT_W = 4;
   localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready, req_we;
   logic [2:0]       req_funct3;
   logic [31:0]      req_addr, req_wdata;
   logic             resp_valid, resp_ready, resp_fault;
   logic [31:0]      resp_rdata;
   logic [3:0]       sram_w_en;
   logic [15:0]      sram_address;
   logic [31:0]      sram_write_data, sram_read_data;
   logic [CNT_W-1:0] cnt_loads, cnt_stores, cnt_faults;

   lsu_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .sram_w_en(sram_w_en), .sram_address(sram_address),
      .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
      .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_faults(cnt_faults)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] rdata; logic fault; int kind;} resp_t; // kind 0 load, 1 store, 2 fault
   typedef struct {logic [3:0] mask; logic [15:0] addr; logic [31:0] data;} wr_t;

   resp_t exp_q[$];
   wr_t   wr_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    rr_mode = 0;   // 0 random, 1 hold low, 2 hold high
   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:65535];

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM model: combinational little-endian read, byte-masked write at the edge.
   logic [15:0] ra1, ra2, ra3;
   assign ra1 = sram_address + 16'd1;
   assign ra2 = sram_address + 16'd2;
   assign ra3 = sram_address + 16'd3;
   assign sram_read_data = {mem[ra3], mem[ra2], mem[ra1], mem[sram_address]};

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         for (int i = 0; i < 4; i++)
            if (sram_w_en[i]) mem[sram_address + 16'(i)] = sram_write_data[8*i +: 8];
      end
   end

   // Reference model applied at issue time, then the request handshake.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int size, a16, n;
      bit legal, flt, sgn;
      logic [31:0] val;
      resp_t r;
      wr_t w;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin chk("accept_timeout", {31'd0, req_ready}, 32'd1); return; end
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      legal = we ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      a16 = int'(a[15:0]);
      flt = (a[31:16] != 0) || !legal || (a16 + size - 1 > 65535);
      if (flt) begin
         r.rdata = 0; r.fault = 1; r.kind = 2;
      end else if (we) begin
         for (int k = 0; k < size; k++) ref_mem[a16 + k] = wd[8*k +: 8];
         w.mask = 4'((1 << size) - 1); w.addr = a[15:0]; w.data = wd;
         wr_q.push_back(w);
         r.rdata = 0; r.fault = 0; r.kind = 1;
      end else begin
         val = 0;
         for (int k = 0; k < size; k++) val = val | (32'(ref_mem[a16 + k]) << (8 * k));
         sgn = (f3 == 0 || f3 == 1);
         if (sgn && size < 4 && val[8*size-1]) val = val - (32'd1 << (8 * size));
         r.rdata = val; r.fault = 0; r.kind = 0;
      end
      exp_q.push_back(r);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic set_mode(input int m);
      @(posedge clk);
      #1 rr_mode = m;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin @(negedge clk); n++; end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: response scoreboard, write scoreboard, backpressure stability, counters.
   initial begin
      int el, es, ef;
      bit hold;
      logic [31:0] h_rdata;
      logic h_fault;
      resp_t r;
      wr_t w;
      el = 0; es = 0; ef = 0; hold = 0; h_rdata = 0; h_fault = 0;
      resp_ready = 0;
      forever begin
         @(negedge clk);
         case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 0;
            default: resp_ready = 1;
         endcase
         if (rst) begin el = 0; es = 0; ef = 0; hold = 0; continue; end
         if (sram_w_en != 4'b0000) begin
            if (wr_q.size() == 0) chk("spurious_write", 32'(sram_w_en), 32'd0);
            else begin
               w = wr_q.pop_front();
               chk("wr_mask", 32'(sram_w_en), 32'(w.mask));
               chk("wr_addr", 32'(sram_address), 32'(w.addr));
               chk("wr_data", sram_write_data, w.data);
            end
         end
         if (hold) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, h_rdata);
            chk("bp_fault", 32'(resp_fault), 32'(h_fault));
         end
         hold = 0;
         if (resp_valid) begin
            chk("ready_in_resp", 32'(req_ready), 32'd0);
            if (resp_ready) begin
               if (exp_q.size() == 0) chk("spurious_resp", 32'(resp_valid), 32'd0);
               else begin
                  r = exp_q.pop_front();
                  if (r.kind == 0) el++; else if (r.kind == 1) es++; else ef++;
                  chk("rdata", resp_rdata, r.rdata);
                  chk("fault", 32'(resp_fault), 32'(r.fault));
                  chk("cnt_loads", 32'(cnt_loads), (el > int'(CNT_MAX)) ? CNT_MAX : 32'(el));
                  chk("cnt_stores", 32'(cnt_stores), (es > int'(CNT_MAX)) ? CNT_MAX : 32'(es));
                  chk("cnt_faults", 32'(cnt_faults), (ef > int'(CNT_MAX)) ? CNT_MAX : 32'(ef));
               end
            end else begin
               hold = 1; h_rdata = resp_rdata; h_fault = resp_fault;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0] f3;
      logic [31:0] a;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
      rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_fault", 32'(resp_fault), 32'd0);
      chk("rst_w_en", 32'(sram_w_en), 32'd0);
      chk("rst_address", 32'(sram_address), 32'd0);
      chk("rst_wdata", sram_write_data, 32'd0);
      chk("rst_cnts", {cnt_loads, cnt_stores, cnt_faults}, 32'd0);
      rst = 0;
      #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

      // Directed: word store/load, extensions, sub-word store, faults.
      issue(1, 3'b010, 32'h100, 32'hDEADBEEF);
      issue(0, 3'b010, 32'h100, 32'h0);
      issue(0, 3'b000, 32'h100, 32'h0);
      issue(0, 3'b100, 32'h100, 32'h0);
      issue(0, 3'b001, 32'h102, 32'h0);
      issue(0, 3'b101, 32'h102, 32'h0);
      issue(1, 3'b000, 32'h201, 32'h12345678);
      issue(0, 3'b010, 32'h200, 32'h0);
      issue(0, 3'b010, 32'hFFFD, 32'h0);
      issue(1, 3'b010, 32'h00010000, 32'hCAFEF00D);
      issue(0, 3'b011, 32'h100, 32'h0);
      issue(0, 3'b000, 32'hFFFF, 32'h0);
      issue(1, 3'b001, 32'hFFFF, 32'h0);
      issue(1, 3'b000, 32'hFFFF, 32'hA5);
      drain();

      // Backpressure: hold response for five cycles, then release.
      set_mode(1);
      issue(0, 3'b010, 32'h100, 32'h0);
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_resp_seen", 32'(resp_valid), 32'd1);
      repeat (5) @(negedge clk);
      set_mode(2);
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_ready", 32'(req_ready), 32'd1);
      chk("bp_idle_valid", 32'(resp_valid), 32'd0);
      set_mode(0);

      // Reset during the ACCESS cycle of a store.
      drain();
      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h11223344;
      @(posedge clk);
      #1 rst = 1;
      req_valid = 0;
      #1 chk("rst_mid_w_en", 32'(sram_w_en), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1 chk("rst_mid_idle", 32'(req_ready), 32'd1);
      chk("rst_mid_valid", 32'(resp_valid), 32'd0);
      chk("rst_mid_cnts", {cnt_loads, cnt_stores, cnt_faults}, 32'd0);
      issue(0, 3'b010, 32'h300, 32'h0);

      // Randomized traffic, long enough to saturate every counter.
      for (int it = 0; it < 300; it++) begin
         n = $urandom_range(0, 9);
         if (n <= 6)      a = 32'h100 + 32'($urandom_range(0, 63));
         else if (n <= 8) a = 32'hFFF8 + 32'($urandom_range(0, 7));
         else             a = $urandom;
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            n = $urandom_range(0, 4);
            f3 = (n < 3) ? 3'(n) : 3'(n + 1);
         end
         issue(1'($urandom_range(0, 1)), f3, a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
